// File: rtl/timer_pkg.sv
// Shared definitions for the interval-timer controller and its counter datapath.
package timer_pkg;
  localparam int WIDTH_DEF   = 8;
  localparam int PRESC_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/timer_count.sv
// Up-counter that wraps to zero at the programmed period and flags the wrap one cycle later.
module timer_count
  import timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             term,
  output logic             wrap
);

  assign term = (count == period);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= cnt_en && term;
      if (clr)
        count <= '0;
      else if (cnt_en)
        count <= term ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer sequencer: latches period/prescale on start, divides the run gate through a
// prescaler and drives the shared counter's enable and clear.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               en,
  input  logic               periodic,
  input  logic [WIDTH-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  output logic               busy,
  output logic               tick,
  output logic               done,
  output logic [WIDTH-1:0]   count
);

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] lat_prescale;
  logic [WIDTH-1:0]   lat_period;
  logic               lat_periodic;
  logic               presc_hit;
  logic               accept;
  logic               cnt_en;
  logic               term;

  assign presc_hit = (presc == lat_prescale);
  assign accept    = (state == IDLE) && start && !stop;
  // Stop and pause both outrank the terminal enable, so the counter only moves when neither is present.
  assign cnt_en    = (state == RUN) && en && !stop && presc_hit;

  timer_count #(.WIDTH(WIDTH)) u_count (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .cnt_en (cnt_en),
    .period (lat_period),
    .count  (count),
    .term   (term),
    .wrap   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      presc        <= '0;
      lat_period   <= '0;
      lat_prescale <= '0;
      lat_periodic <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_period   <= period;
            lat_prescale <= prescale;
            lat_periodic <= periodic;
            presc        <= '0;
            state        <= RUN;
            busy         <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            presc <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!en) begin
            state <= HOLD;
          end else begin
            presc <= presc_hit ? '0 : presc + 1'b1;
            if (presc_hit && term && !lat_periodic) begin
              done  <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            presc <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (en) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed timing scenarios plus random stimulus against a progress-based model.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, en, periodic;
  logic [7:0] period, prescale;
  logic       busy, tick, done;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  // Reference model: progress counts active edges since start; a wrap happens every (P+1)*(S+1) of them.
  int m_st = 0;  // 0 idle, 1 run, 2 hold
  int m_p = 0, m_cnt = 0, m_tick = 0, m_done = 0;
  int m_P = 0, m_S = 0, m_per = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.WIDTH(8), .PRESC_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .periodic (periodic),
    .period   (period),
    .prescale (prescale),
    .busy     (busy),
    .tick     (tick),
    .done     (done),
    .count    (count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, ncyc);
    end
  endtask

  task automatic model_step();
    m_tick = 0;
    m_done = 0;
    if (rst) begin
      m_st = 0; m_p = 0; m_cnt = 0; m_P = 0; m_S = 0; m_per = 0;
    end else begin
      case (m_st)
        0: if (start && !stop) begin
          m_P = period; m_S = prescale; m_per = periodic;
          m_p = 0; m_cnt = 0; m_st = 1;
        end
        1: if (stop) m_st = 0;
           else if (!en) m_st = 2;
           else begin
             m_p++;
             if (m_p == (m_P + 1) * (m_S + 1)) begin
               m_p = 0; m_cnt = 0; m_tick = 1;
               if (!m_per) begin m_done = 1; m_st = 0; end
             end else begin
               m_cnt = m_p / (m_S + 1);
             end
           end
        default: if (stop) m_st = 0;
                 else if (en) m_st = 1;
      endcase
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    ncyc++;
    chk("count", count, m_cnt);
    chk("busy", busy, (m_st != 0) ? 1 : 0);
    chk("tick", tick, m_tick);
    chk("done", done, m_done);
  endtask

  task automatic do_start(input int p, input int s, input int per);
    period = p[7:0]; prescale = s[7:0]; periodic = per[0];
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Returns cycles from edge e0 to the edge after which tick is high, or -1 on timeout.
  task automatic wait_tick(input int e0, input int bound, output int dt);
    dt = -1;
    for (int i = 0; i < bound; i++) begin
      cyc();
      if (tick) begin
        dt = ncyc - e0;
        break;
      end
    end
  endtask

  initial begin
    int e0, dt, t_prev;
    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b1; periodic = 1'b0;
    period = '0; prescale = '0;

    // Reset and idle
    cyc(); cyc();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("idle_busy", busy, 0);

    // One-shot, period 3, no prescale: tick and done four edges after start
    do_start(3, 0, 0);
    e0 = ncyc;
    chk("os_busy", busy, 1);
    wait_tick(e0, 20, dt);
    chk("os_latency", dt, 4);
    chk("os_done", done, 1);
    chk("os_busy_fall", busy, 0);
    cyc();

    // Periodic, period 2, prescale 1: spacing of 6, start mid-run ignored
    do_start(2, 1, 1);
    e0 = ncyc;
    wait_tick(e0, 20, dt);
    chk("per_first", dt, 6);
    for (int k = 0; k < 4; k++) begin
      t_prev = ncyc;
      if (k == 1) begin
        period = 8'd7; prescale = 8'd3; periodic = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
      end
      wait_tick(t_prev, 20, dt);
      chk("per_spacing", dt, 6);
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("per_stopped", busy, 0);

    // Pause at count 2: the pausing edge and each held cycle skip counting
    do_start(4, 0, 1);
    e0 = ncyc;
    cyc(); cyc();
    chk("pause_pre", count, 2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("pause_hold", count, 2);
    chk("pause_busy", busy, 1);
    en = 1'b1;
    wait_tick(e0, 30, dt);
    chk("pause_latency", dt, 5 + 3 + 1);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Stop coincident with the terminal enable suppresses tick and done
    do_start(1, 0, 0);
    cyc();
    chk("sw_pre", count, 1);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("sw_tick", tick, 0);
    chk("sw_done", done, 0);
    chk("sw_busy", busy, 0);
    chk("sw_count", count, 1);
    cyc();

    // Period 0, prescale 0: tick every cycle
    do_start(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("p0_tick", tick, 1);
    end
    stop = 1'b1; cyc(); stop = 1'b0;

    // Full-range one-shot
    do_start(255, 255, 0);
    e0 = ncyc;
    wait_tick(e0, 70000, dt);
    chk("max_latency", dt, 65536);
    chk("max_done", done, 1);

    // Reset mid-run
    do_start(9, 2, 1);
    for (int i = 0; i < 7; i++) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_tick", tick, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 40) == 0);
      en       = ($urandom_range(0, 7) != 0);
      periodic = $urandom_range(0, 1);
      period   = 8'($urandom_range(0, 7));
      prescale = 8'($urandom_range(0, 3));
      rst      = ($urandom_range(0, 300) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
